// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine input front end.
// Holds the channel count and the bit position of each pad input within
// raw_in, level_out and pulse_out. It also holds the default debounce length.
package vm_pkg;

  localparam int N_VM_IN       = 4;

  localparam int IDX_COIN      = 0;
  localparam int IDX_ACCEPT    = 1;
  localparam int IDX_RST_MOORE = 2;
  localparam int IDX_RST_MEALY = 3;

  localparam int DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/vm_debounce_channel.sv
// One conditioned pad input.
// The raw input passes through a SYNC_STAGES-deep synchronizer and is then
// debounced against a stable level. The stable level flips only after the
// synchronized value has differed from it for DEBOUNCE_CYCLES consecutive
// clock edges.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset; clears the synchronizer,
//             the counter and the stable level
//   raw_in    asynchronous pad input
//   level     stable (debounced) level, driven directly from a register
//   raw_pulse combinational; high during the cycle in which the stable
//             level is about to flip 0->1. The parent registers it, so the
//             registered pulse lines up with the new level.
module vm_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic raw_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync;
  logic                   stable_p1;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   flip;

  assign sync = sync_p0[SYNC_STAGES-1];
  assign flip = (sync != stable_p1) && (cnt_p1 == CNT_LAST);

  // Stage p0: metastability synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Stage p1: debounce counter and stable level.
  // Any cycle in which sync agrees with the stable level restarts the count.
  // As a result, only an uninterrupted run of disagreement can flip the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else if (sync == stable_p1) begin
      cnt_p1    <= '0;
    end else if (flip) begin
      stable_p1 <= sync;
      cnt_p1    <= '0;
    end else begin
      cnt_p1    <= cnt_p1 + CNT_W'(1);
    end
  end

  assign level     = stable_p1;
  assign raw_pulse = flip & sync;

endmodule

// File: rtl/vm_input_conditioner.sv
// Front end placed ahead of the vending-machine FSM.
// It synchronizes and debounces the four pad inputs (coin, accept, Moore reset
// button and Mealy reset button). It then produces a clean level and a
// one-cycle rising-edge pulse per input.
// A reset-button event in a given cycle suppresses coin/accept pulses in that
// same cycle. ena=0 suppresses all pulses, but debouncing keeps running.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   ena       enable; low forces pulse_out to zero
//   raw_in    [0]=coin m, [1]=accept a, [2]=btnC Moore reset,
//             [3]=btnD Mealy reset (asynchronous)
//   level_out debounced stable level per channel
//   pulse_out registered one-cycle pulse per debounced 0->1 transition,
//             after priority masking and enable gating
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = vm_pkg::DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_VM_IN-1:0] raw_in,
  output logic [N_VM_IN-1:0] level_out,
  output logic [N_VM_IN-1:0] pulse_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [N_VM_IN-1:0] raw_pulse;
  logic [N_VM_IN-1:0] pulse_p2;

  // Reset-button events take priority over coin/accept events.
  // Coin/accept events in the same cycle as a reset-button event are dropped,
  // not held for later.
  function automatic logic [N_VM_IN-1:0] priority_mask(
    input logic [N_VM_IN-1:0] p,
    input logic               en
  );
    logic [N_VM_IN-1:0] m;
    m = p;
    if (p[IDX_RST_MOORE] || p[IDX_RST_MEALY]) begin
      m[IDX_COIN]   = 1'b0;
      m[IDX_ACCEPT] = 1'b0;
    end
    if (!en) begin
      m = '0;
    end
    return m;
  endfunction

  for (genvar i = 0; i < N_VM_IN; i++) begin : g_ch
    vm_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in[i]),
      .level     (level_out[i]),
      .raw_pulse (raw_pulse[i])
    );
  end

  // Stage p2: masked pulse register, updated on the same edge as the stable level
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_p2 <= '0;
    end else begin
      pulse_p2 <= priority_mask(raw_pulse, ena);
    end
  end

  assign pulse_out = pulse_p2;

endmodule

// File: tb/tb_vm_input_conditioner.sv
module tb_vm_input_conditioner;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] raw_in = 4'b0000;
  logic [3:0] level_out;
  logic [3:0] pulse_out;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt1 = 0;

  vm_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .raw_in    (raw_in),
    .level_out (level_out),
    .pulse_out (pulse_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The synchronizer is modelled as a delay line of raw samples.
  // A level flips once the last D synchronized samples all disagree with it.
  logic [7:0] exp_q[$];
  logic [3:0] win[$];
  logic [3:0] dl[S];
  logic [3:0] m_stable = 4'b0000;

  always @(posedge clk) begin
    logic [3:0] sync, flip, rise;
    logic       all_diff;
    rise = 4'b0000;
    if (rst) begin
      for (int s = 0; s < S; s++) dl[s] = 4'b0000;
      win.delete();
      m_stable = 4'b0000;
    end else begin
      sync = dl[S-1];
      win.push_back(sync);
      if (win.size() > D) void'(win.pop_front());
      flip = 4'b0000;
      if (win.size() == D) begin
        for (int c = 0; c < 4; c++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][c] == m_stable[c]) all_diff = 1'b0;
          flip[c] = all_diff;
        end
      end
      rise = flip & sync & ~m_stable;
      m_stable = m_stable ^ flip;
      for (int s = S - 1; s > 0; s--) dl[s] = dl[s-1];
      dl[0] = raw_in;
      if (rise[2] || rise[3]) rise[1:0] = 2'b00;
      if (!ena) rise = 4'b0000;
    end
    exp_q.push_back({m_stable, rise});
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({level_out, pulse_out} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got level=%b pulse=%b want level=%b pulse=%b",
                 $time, level_out, pulse_out, e[7:4], e[3:0]);
      end
      if (pulse_out[1] === 1'b1) pulse_cnt1++;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r);
    @(negedge clk);
    raw_in = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    edges(20);
    check("idle_level", {4'b0, level_out}, 8'h00);
    check("idle_pulse", {4'b0, pulse_out}, 8'h00);

    // coin press: visible on edge 6, one-cycle pulse
    drive(4'b0001);
    edges(5);
    check("coin_lvl_e5", {4'b0, level_out}, 8'h00);
    edges(1);
    check("coin_lvl_e6", {4'b0, level_out}, 8'h01);
    check("coin_pls_e6", {4'b0, pulse_out}, 8'h01);
    edges(1);
    check("coin_pls_e7", {4'b0, pulse_out}, 8'h00);
    edges(6);

    // coin release: level drops on edge 6, no pulse
    drive(4'b0000);
    edges(5);
    check("rel_lvl_e5", {4'b0, level_out}, 8'h01);
    edges(1);
    check("rel_lvl_e6", {4'b0, level_out}, 8'h00);
    check("rel_pls_e6", {4'b0, pulse_out}, 8'h00);
    edges(6);

    // 3-cycle glitch on accept is rejected
    drive(4'b0010);
    repeat (2) @(negedge clk);
    drive(4'b0000);
    edges(12);
    check("glitch_lvl", {4'b0, level_out}, 8'h00);
    check("glitch_cnt", 8'(pulse_cnt1), 8'd0);

    // bounce inside a 10-cycle press yields exactly one pulse
    pulse_cnt1 = 0;
    drive(4'b0010);
    repeat (2) @(negedge clk);
    drive(4'b0000);
    drive(4'b0010);
    repeat (5) @(negedge clk);
    drive(4'b0000);
    edges(16);
    check("bounce_cnt", 8'(pulse_cnt1), 8'd1);

    // coin with btnC, coin with btnD, btnC with btnD
    drive(4'b0101);
    edges(6);
    check("coin_btnc_pls", {4'b0, pulse_out}, 8'h04);
    check("coin_btnc_lvl", {4'b0, level_out}, 8'h05);
    drive(4'b0000);
    edges(12);
    drive(4'b1001);
    edges(6);
    check("coin_btnd_pls", {4'b0, pulse_out}, 8'h08);
    check("coin_btnd_lvl", {4'b0, level_out}, 8'h09);
    drive(4'b0000);
    edges(12);
    drive(4'b1100);
    edges(6);
    check("btn_both_pls", {4'b0, pulse_out}, 8'h0C);
    drive(4'b0000);
    edges(12);

    // ena low: level follows, pulse lost, no catch-up
    pulse_cnt1 = 0;
    @(negedge clk);
    ena = 1'b0;
    raw_in = 4'b0010;
    edges(8);
    check("ena0_lvl", {4'b0, level_out}, 8'h02);
    @(negedge clk);
    ena = 1'b1;
    edges(8);
    check("ena_cnt", 8'(pulse_cnt1), 8'd0);
    drive(4'b0000);
    edges(12);

    // reset during debounce of btnD, then held through release
    drive(4'b1000);
    edges(2);
    @(negedge clk);
    rst = 1'b1;
    edges(1);
    check("midrst_lvl", {4'b0, level_out}, 8'h00);
    check("midrst_pls", {4'b0, pulse_out}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    edges(5);
    check("postrst_e5", {4'b0, pulse_out}, 8'h00);
    edges(1);
    check("postrst_e6", {4'b0, pulse_out}, 8'h08);
    check("postrst_lvl", {4'b0, level_out}, 8'h08);
    drive(4'b0000);
    edges(12);

    // randomized holds, ena toggles and occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      @(negedge clk);
      raw_in = 4'($urandom);
      ena    = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 39) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      rst = 1'b0;
    end

    @(negedge clk);
    raw_in = 4'b0000;
    ena = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
